// File: rtl/brain_steer_if.sv
// Bus between the brain-data receiver / front panel and the steering decoder.
// The master drives the packet bytes and buttons, the slave returns turn pulses and debug state.
interface brain_steer_if #(parameter int DW = 8);
    logic          sample_valid;
    logic [DW-1:0] signal_data;
    logic [DW-1:0] attention_data;
    logic [DW-1:0] meditation_data;
    logic          man_control;
    logic          left_bt;
    logic          right_bt;
    logic          turn_left;
    logic          turn_right;
    logic          brain_active;
    logic [1:0]    fsm_state;

    modport master (
        output sample_valid, signal_data, attention_data, meditation_data,
               man_control, left_bt, right_bt,
        input  turn_left, turn_right, brain_active, fsm_state
    );
    modport slave (
        input  sample_valid, signal_data, attention_data, meditation_data,
               man_control, left_bt, right_bt,
        output turn_left, turn_right, brain_active, fsm_state
    );
endinterface

// File: rtl/brain_steer_decoder.sv
// Turns brain packets (quality/attention/meditation) or debounced buttons into
// single-cycle left/right turn pulses, with N-sample voting and post-turn cooldown.
module brain_steer_decoder #(
    parameter int DW       = 8,
    parameter int ATT_TH   = 60,
    parameter int MED_TH   = 60,
    parameter int SIG_MAX  = 50,
    parameter int HOLD     = 3,
    parameter int COOLDOWN = 4,
    parameter int DB_CYC   = 500000
) (
    input  logic         clk,
    input  logic         rst,
    brain_steer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_COOL = 2'd2} state_t;
    typedef enum logic [1:0] {V_NONE = 2'd0, V_LEFT = 2'd1, V_RIGHT = 2'd2} vote_t;

    localparam int RW  = $clog2(HOLD + 1);
    localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int DBW = $clog2(DB_CYC + 1);
    localparam logic [RW-1:0]  RUN_MAX = RW'(HOLD);
    localparam logic [CDW-1:0] CD_INIT = CDW'(COOLDOWN);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);
    localparam logic [DW-1:0]  SIG_LIM = DW'(SIG_MAX);
    localparam logic [DW-1:0]  ATT_LIM = DW'(ATT_TH);
    localparam logic [DW-1:0]  MED_LIM = DW'(MED_TH);

    logic                r_man_s1, r_man_s2, r_man_d, r_chg_d;
    logic [1:0]          r_bt_s1, r_bt_s2, r_stab, r_stab_d;
    logic [1:0][DBW-1:0] r_db_cnt;
    state_t              r_state;
    vote_t               r_vote;
    logic [RW-1:0]       r_run;
    logic [CDW-1:0]      r_cool;
    logic                r_turn_l, r_turn_r, r_active;

    logic          w_mode_chg, w_good, w_fire;
    logic [1:0]    w_rise;
    vote_t         w_cls, w_vote_nxt;
    logic [RW-1:0] w_run_nxt;

    assign w_mode_chg = r_man_s2 ^ r_man_d;
    assign w_rise     = r_stab & ~r_stab_d;
    assign w_good     = bus.signal_data <= SIG_LIM;

    // Index 0 is the left button, 1 the right; debouncers run in both modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bt_s1  <= '0;
            r_bt_s2  <= '0;
            r_stab   <= '0;
            r_stab_d <= '0;
            r_db_cnt <= '0;
        end else begin
            r_bt_s1  <= {bus.right_bt, bus.left_bt};
            r_bt_s2  <= r_bt_s1;
            r_stab_d <= r_stab;
            for (int b = 0; b < 2; b++) begin
                if (r_bt_s2[b] == r_stab[b]) begin
                    r_db_cnt[b] <= '0;
                end else if (r_db_cnt[b] == DB_LAST) begin
                    r_db_cnt[b] <= '0;
                    r_stab[b]   <= r_bt_s2[b];
                end else begin
                    r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cls = V_NONE;
        if (bus.attention_data >= ATT_LIM && bus.meditation_data < MED_LIM)
            w_cls = V_LEFT;
        else if (bus.meditation_data >= MED_LIM && bus.attention_data < ATT_LIM)
            w_cls = V_RIGHT;
    end

    // NONE breaks the run but keeps the stored vote; a new direction restarts at 1.
    always_comb begin
        w_vote_nxt = r_vote;
        w_run_nxt  = r_run;
        w_fire     = 1'b0;
        if (w_cls == V_NONE) begin
            w_run_nxt = '0;
        end else if (w_cls == r_vote) begin
            w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;
        end else begin
            w_vote_nxt = w_cls;
            w_run_nxt  = RW'(1);
        end
        if (w_cls != V_NONE && w_run_nxt == RUN_MAX)
            w_fire = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_man_s1 <= 1'b0;
            r_man_s2 <= 1'b0;
            r_man_d  <= 1'b0;
            r_chg_d  <= 1'b0;
            r_state  <= S_IDLE;
            r_vote   <= V_NONE;
            r_run    <= '0;
            r_cool   <= '0;
            r_turn_l <= 1'b0;
            r_turn_r <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_man_s1 <= bus.man_control;
            r_man_s2 <= r_man_s1;
            r_man_d  <= r_man_s2;
            r_chg_d  <= w_mode_chg;
            r_turn_l <= 1'b0;
            r_turn_r <= 1'b0;
            if (w_mode_chg || r_man_s2) begin
                r_state  <= S_IDLE;
                r_vote   <= V_NONE;
                r_run    <= '0;
                r_cool   <= '0;
                r_active <= 1'b0;
                if (r_man_s2 && !w_mode_chg && !r_chg_d) begin
                    r_turn_l <= w_rise[0] & ~w_rise[1];
                    r_turn_r <= w_rise[1] & ~w_rise[0];
                end
            end else if (bus.sample_valid) begin
                if (!w_good) begin
                    r_state  <= S_IDLE;
                    r_vote   <= V_NONE;
                    r_run    <= '0;
                    r_cool   <= '0;
                    r_active <= 1'b0;
                end else begin
                    r_active <= 1'b1;
                    if (r_state == S_COOL) begin
                        // The sample that empties the cooldown is consumed, not classified.
                        if (r_cool <= CDW'(1)) begin
                            r_cool  <= '0;
                            r_state <= S_TRACK;
                        end else begin
                            r_cool <= r_cool - 1'b1;
                        end
                    end else begin
                        r_state <= S_TRACK;
                        if (w_fire) begin
                            r_run    <= '0;
                            r_vote   <= V_NONE;
                            r_turn_l <= (w_vote_nxt == V_LEFT) && !r_chg_d;
                            r_turn_r <= (w_vote_nxt == V_RIGHT) && !r_chg_d;
                            if (COOLDOWN > 0) begin
                                r_state <= S_COOL;
                                r_cool  <= CD_INIT;
                            end
                        end else begin
                            r_run  <= w_run_nxt;
                            r_vote <= w_vote_nxt;
                        end
                    end
                end
            end
        end
    end

    assign bus.turn_left    = r_turn_l;
    assign bus.turn_right   = r_turn_r;
    assign bus.brain_active = r_active;
    assign bus.fsm_state    = r_state;
endmodule

// File: doc/brain_steer_decoder.md
# brain_steer_decoder

Parametrised steering decoder between the RS232 brain-data receiver and the snake game core. It turns per-packet signal quality, attention and meditation bytes into single-cycle left/right turn pulses. Rules: signal-quality gating, N-consecutive-sample voting and a post-turn cooldown. In manual mode it takes debounced front-panel buttons instead.

## Interface
Parameters:
- DW, 8, width of each brain data byte
- ATT_TH, 60, attention threshold, unsigned, inclusive
- MED_TH, 60, meditation threshold, unsigned, inclusive
- SIG_MAX, 50, largest signal_data value accepted as good contact (0 = best)
- HOLD, 3, consecutive identical votes needed to emit a turn (≥1)
- COOLDOWN, 4, valid samples ignored after a brain turn (≥0)
- DB_CYC, 500000, button stable-cycles for debounce (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe, new packet bytes valid
- signal_data  in  DW  poor-signal value
- attention_data  in  DW  attention value
- meditation_data  in  DW  meditation value
- man_control  in  1  1 = manual buttons, 0 = brain control; asynchronous, synchronised internally
- left_bt, right_bt  in  1  raw push buttons, active-high, asynchronous
- turn_left, turn_right  out  1  registered one-cycle turn pulses
- brain_active  out  1  level, last valid sample had good signal (brain mode only)
- fsm_state  out  2  debug: 0 IDLE, 1 TRACK, 2 COOL

## Operation
- Reset state:
  - outputs 0, FSM IDLE, run counter 0, vote register NONE, cooldown 0
  - synchroniser and debounce registers 0
- Manual mode (synchronised man_control = 1):
  - left_bt/right_bt each pass a 2-FF synchroniser, then a debouncer. The stable value updates after DB_CYC consecutive cycles of unchanged input.
  - A rising edge of a stable value gives one pulse.
  - Both stable edges in the same cycle: no pulse.
  - Brain inputs are ignored; FSM is held in IDLE; brain_active = 0.
- Brain mode (synchronised man_control = 0). Button edges are ignored, but the debouncers keep tracking. Evaluation happens only on a sample_valid cycle.
  - signal_data > SIG_MAX:
    - brain_active ← 0, run ← 0, vote ← NONE, FSM → IDLE
    - any remaining cooldown is cancelled
  - Otherwise brain_active ← 1, and the sample is classified:
    - LEFT if attention ≥ ATT_TH and meditation < MED_TH
    - RIGHT if meditation ≥ MED_TH and attention < ATT_TH
    - otherwise NONE
  - IDLE → TRACK on the first good sample, which is also evaluated as below.
  - TRACK: the counted run is handled as follows.
    - NONE sets run ← 0.
    - A class equal to the stored vote increments run.
    - A different non-NONE class sets vote ← class and run ← 1.
    - When run reaches HOLD, pulse the vote direction and set run ← 0, vote ← NONE.
    - FSM → COOL if COOLDOWN > 0, else it stays in TRACK.
  - COOL: each good sample decrements the cooldown. At 0 the FSM returns to TRACK and the sample that empties it is not classified. No pulses occur in COOL.
- Mode change (synchronised man_control toggles):
  - brain counters clear and FSM → IDLE
  - no pulse in the toggle cycle or the next cycle
- turn_left and turn_right are never high together. The run counter width is $clog2(HOLD+1) and saturates at HOLD.

## Timing
- Brain pulse: asserted the cycle after the qualifying sample_valid, width exactly 1 cycle.
- Button pulse: 2 sync cycles + DB_CYC stable cycles + 1 register cycle after the raw edge. Width 1 cycle regardless of how long the button is held.
- brain_active and fsm_state update the cycle after sample_valid.
- sample_valid on consecutive cycles is legal; each sample is evaluated.
- rst asserted mid-run or mid-cooldown: all state is at reset values on the next edge, and a pulse pending from that cycle is suppressed.

## Test plan
- Reset: hold rst 3 cycles, then release → all outputs 0, fsm_state 0.
- Brain left with defaults: three samples (sig 0, att 70, med 20).
  - Expected: turn_left high exactly 1 cycle after the 3rd strobe.
  - Four more such samples give no pulse (COOL).
  - The 8th through 10th samples produce the next pulse after the 10th.
- Vote breaks:
  - Samples L, L, R, R, R → one turn_right after the 5th only.
  - Samples L, L, (att 70, med 70), L → no pulse.
- Signal loss:
  - L, L, then sig 200 → brain_active 0, fsm_state 0.
  - Next L, L, L → turn_left after the 3rd.
- Manual with DB_CYC=4:
  - Glitch on left_bt of 2 cycles → no pulse.
  - Hold left_bt 20 cycles → one turn_left about 7 cycles after the edge.
  - Simultaneous left+right → no pulse.
- Mode switch mid-run: L, L, toggle man_control 1 then 0, then one L → no pulse. Two more L samples are needed for a pulse.
